simple_axi_wr_slave: RTL

AXI4 write-only responder (slave) with a 64-bit data bus, accepting single-beat and INCR burst writes into a DEPTH-word window at BASE_ADDR. Every accepted beat is presented on a registered user write port for register-file or BRAM logic. It sits on the same interconnect as our AXI write masters and serves as a bench-side or PL-side target for their transactions.

---
 rtl/simple_axi_wr_slave.sv | 188 ++++++++++++++++++
 1 files changed

// File: rtl/simple_axi_wr_slave.sv
// simple_axi_wr_slave: AXI4 write-only slave for a 2^DEPTH_LOG2 x 64-bit window
// at BASE_ADDR. Each accepted in-window beat is replayed one cycle later on a
// registered user write port (wr_en/wr_index/wr_data/wr_strb).
module simple_axi_wr_slave #(
   parameter logic [39:0] BASE_ADDR  = 40'h00_2000_0000,
   parameter int unsigned DEPTH_LOG2 = 4
) (
   input  logic                  ACLK,
   input  logic                  ARESETn,
   // write address channel
   input  logic [3:0]            S_AXI_AWID,
   input  logic [39:0]           S_AXI_AWADDR,
   input  logic [7:0]            S_AXI_AWLEN,
   input  logic [2:0]            S_AXI_AWSIZE,
   input  logic [1:0]            S_AXI_AWBURST,
   input  logic                  S_AXI_AWVALID,
   output logic                  S_AXI_AWREADY,
   // write data channel
   input  logic [63:0]           S_AXI_WDATA,
   input  logic [7:0]            S_AXI_WSTRB,
   input  logic                  S_AXI_WLAST,
   input  logic                  S_AXI_WVALID,
   output logic                  S_AXI_WREADY,
   // write response channel
   output logic [3:0]            S_AXI_BID,
   output logic [1:0]            S_AXI_BRESP,
   output logic                  S_AXI_BVALID,
   input  logic                  S_AXI_BREADY,
   // user write port
   output logic                  wr_en,
   output logic [DEPTH_LOG2-1:0] wr_index,
   output logic [63:0]           wr_data,
   output logic [7:0]            wr_strb,
   output logic [31:0]           wr_count
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_DATA = 2'd1,
      S_RESP = 2'd2
   } state_t;

   // First byte past the window, kept 42 bits wide so the bound never wraps.
   localparam logic [41:0] WIN_END = {2'b00, BASE_ADDR} + (42'd1 << (DEPTH_LOG2 + 3));

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;

   state_t                  state;
   state_t                  state_next;

   logic [3:0]              id_q;
   logic [DEPTH_LOG2-1:0]   idx_q;
   logic [7:0]              len_q;
   logic [7:0]              beat_q;
   logic                    err_q;

   logic [41:0]             aw_end;
   logic [39:0]             aw_offset;
   logic                    aw_err;
   logic                    unused_offset_bits;

   logic                    aw_hs;
   logic                    w_hs;
   logic                    b_hs;
   logic                    w_last_count;
   logic                    w_end;
   logic                    w_mismatch;
   logic                    w_commit;

   // Decode the AW request: window/size/burst checks and start index.
   always_comb begin
      aw_end    = {2'b00, S_AXI_AWADDR} + (({34'd0, S_AXI_AWLEN} + 42'd1) << 3);
      aw_offset = S_AXI_AWADDR - BASE_ADDR;
      aw_err    = (S_AXI_AWSIZE != 3'b011)
               || (S_AXI_AWBURST != 2'b01)
               || (S_AXI_AWADDR[2:0] != 3'b000)
               || (S_AXI_AWADDR < BASE_ADDR)
               || (aw_end > WIN_END);
   end

   assign unused_offset_bits = ^{aw_offset[39:DEPTH_LOG2+3], aw_offset[2:0]};

   // Handshakes and per-beat burst-end / commit decisions.
   always_comb begin
      aw_hs        = (state == S_IDLE) && S_AXI_AWVALID;
      w_hs         = (state == S_DATA) && S_AXI_WVALID;
      b_hs         = (state == S_RESP) && S_AXI_BREADY;
      w_last_count = (beat_q == len_q);
      w_end        = S_AXI_WLAST || w_last_count;
      // A disagreement always implies one side is set, i.e. it is the end beat.
      w_mismatch   = (S_AXI_WLAST != w_last_count);
      w_commit     = w_hs && !err_q && !w_mismatch;
   end

   // State register.
   always_ff @(posedge ACLK or negedge ARESETn) begin
      if (!ARESETn) begin
         state <= S_IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Next-state logic and channel ready/valid outputs.
   always_comb begin
      state_next    = state;
      S_AXI_AWREADY = 1'b0;
      S_AXI_WREADY  = 1'b0;
      S_AXI_BVALID  = 1'b0;
      case (state)
         S_IDLE: begin
            S_AXI_AWREADY = 1'b1;
            if (S_AXI_AWVALID) begin
               state_next = S_DATA;
            end
         end
         S_DATA: begin
            S_AXI_WREADY = 1'b1;
            if (S_AXI_WVALID && w_end) begin
               state_next = S_RESP;
            end
         end
         S_RESP: begin
            S_AXI_BVALID = 1'b1;
            if (S_AXI_BREADY) begin
               state_next = S_IDLE;
            end
         end
         default: begin
            state_next = S_IDLE;
         end
      endcase
   end

   // Transaction context: ID, running index, beat counter and sticky error.
   always_ff @(posedge ACLK or negedge ARESETn) begin
      if (!ARESETn) begin
         id_q   <= '0;
         idx_q  <= '0;
         len_q  <= '0;
         beat_q <= '0;
         err_q  <= 1'b0;
      end else if (aw_hs) begin
         id_q   <= S_AXI_AWID;
         idx_q  <= aw_offset[DEPTH_LOG2+2:3];
         len_q  <= S_AXI_AWLEN;
         beat_q <= '0;
         err_q  <= aw_err;
      end else if (w_hs) begin
         idx_q  <= idx_q + 1'b1;
         beat_q <= beat_q + 8'd1;
         if (w_mismatch) begin
            err_q <= 1'b1;
         end
      end
   end

   // Registered user write port: one wr_en pulse per committed beat.
   always_ff @(posedge ACLK or negedge ARESETn) begin
      if (!ARESETn) begin
         wr_en    <= 1'b0;
         wr_index <= '0;
         wr_data  <= '0;
         wr_strb  <= '0;
      end else begin
         wr_en <= w_commit;
         if (w_commit) begin
            wr_index <= idx_q;
            wr_data  <= S_AXI_WDATA;
            wr_strb  <= S_AXI_WSTRB;
         end
      end
   end

   // Count bursts that completed with OKAY at their B handshake.
   always_ff @(posedge ACLK or negedge ARESETn) begin
      if (!ARESETn) begin
         wr_count <= '0;
      end else if (b_hs && !err_q) begin
         wr_count <= wr_count + 32'd1;
      end
   end

   assign S_AXI_BID   = id_q;
   assign S_AXI_BRESP = err_q ? RESP_SLVERR : RESP_OKAY;

endmodule
